// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel/line counters, sync pulses, blanking and
// line/frame/vblank event strobes, all registered with zero skew to pix_x/pix_y.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_raster
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must both be <= 1024");
  end

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] pix_x_q, pix_x_d;
  logic [9:0] pix_y_q, pix_y_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_q, blank_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       vblank_start_q, vblank_start_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    pix_x_d        = pix_x_q;
    pix_y_d        = pix_y_q;
    frame_cnt_d    = frame_cnt_q;
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    blank_d        = blank_q;
    line_start_d   = 1'b0;
    frame_start_d  = 1'b0;
    vblank_start_d = 1'b0;

    if (pix_ce) begin
      if (pix_x_q == H_LAST) begin
        pix_x_d      = '0;
        line_start_d = 1'b1;
        if (pix_y_q == V_LAST) begin
          pix_y_d       = '0;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 8'd1;
        end else begin
          pix_y_d        = pix_y_q + 10'd1;
          vblank_start_d = (pix_y_d == V_VIS);
        end
      end else begin
        pix_x_d = pix_x_q + 10'd1;
      end

      // Decoded from the next-state counters so they line up with pix_x/pix_y.
      hsync_d = (pix_x_d >= HS_FIRST && pix_x_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
      vsync_d = (pix_y_d >= VS_FIRST && pix_y_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
      blank_d = (pix_x_d >= H_VIS) || (pix_y_d >= V_VIS);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      frame_cnt_q    <= '0;
      hsync_q        <= ~SYNC_POL;
      vsync_q        <= ~SYNC_POL;
      blank_q        <= 1'b0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      pix_x_q        <= pix_x_d;
      pix_y_q        <= pix_y_d;
      frame_cnt_q    <= frame_cnt_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      blank_q        <= blank_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign frame_cnt    = frame_cnt_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign blank        = blank_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;

endmodule
